// File: rtl/bmem_arbiter_if.sv
// Cache-side dfp ports and the shared burst-memory port of the bmem arbiter, bundled.
// The arbiter takes the slave view. The master view is the caches plus the memory.
interface bmem_arbiter_if #(
  parameter int LINE_W = 256
);
  logic [31:0]       i_dfp_addr;
  logic              i_dfp_read;
  logic [LINE_W-1:0] i_dfp_rdata;
  logic              i_dfp_resp;

  logic [31:0]       d_dfp_addr;
  logic              d_dfp_read;
  logic              d_dfp_write;
  logic [LINE_W-1:0] d_dfp_wdata;
  logic [LINE_W-1:0] d_dfp_rdata;
  logic              d_dfp_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [63:0]       bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [63:0]       bmem_rdata;
  logic              bmem_rvalid;

  modport slave (
    input  i_dfp_addr, i_dfp_read,
    input  d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output i_dfp_rdata, i_dfp_resp, d_dfp_rdata, d_dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport master (
    output i_dfp_addr, i_dfp_read,
    output d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  i_dfp_rdata, i_dfp_resp, d_dfp_rdata, d_dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter that shares the 64-bit burst memory between icache and dcache.
// It serialises writeback lines into beats and assembles returning read beats into lines.
module bmem_arbiter #(
  parameter int BEATS  = 4,
  parameter int LINE_W = 256
) (
  input  logic          clk,
  input  logic          rst,
  bmem_arbiter_if.slave bus,
  output logic [2:0]    dbg_state
);
  // Handshakes: a read request completes on the cycle where bmem_read and
  // bmem_ready are both high. A write beat completes on the cycle where
  // bmem_write and bmem_ready are both high. A read beat is consumed on every
  // cycle where bmem_rvalid is high.
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_DATA  = 3'd2,
    WR_BURST = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     beat;
  logic              last_grant;  // 1 = dcache
  logic              owner;       // 1 = dcache
  logic              mask_prev;
  logic [31:0]       addr_q;
  logic [31:0]       req_addr;
  logic [LINE_W-1:0] wdata_q, line_q, line_nxt, i_rdata_q, d_rdata_q;
  logic              i_req, d_req, grant, grant_d, grant_wr;
  logic              beat_done, last_beat;

  // The previous owner still holds its request in the cycle after RESP, so it is masked out for that cycle.
  always_comb begin
    i_req     = bus.i_dfp_read && !(mask_prev && !owner);
    d_req     = (bus.d_dfp_read || bus.d_dfp_write) && !(mask_prev && owner);
    grant     = (state == IDLE) && (i_req || d_req);
    grant_d   = d_req && (!i_req || !last_grant);
    grant_wr  = grant_d && bus.d_dfp_write;
    req_addr  = (grant_d ? bus.d_dfp_addr : bus.i_dfp_addr) & ADDR_MASK;
    beat_done = ((state == RD_DATA) && bus.bmem_rvalid) ||
                ((state == WR_BURST) && bus.bmem_ready);
    last_beat = beat_done && (beat == LAST);
    line_nxt  = line_q;
    line_nxt[64*beat +: 64] = bus.bmem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant) state_nxt = grant_wr ? WR_BURST : RD_REQ;
      RD_REQ:   if (bus.bmem_ready) state_nxt = RD_DATA;
      RD_DATA:  if (last_beat) state_nxt = RESP;
      WR_BURST: if (last_beat) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.bmem_read   = 1'b0;
    bus.bmem_write  = 1'b0;
    bus.bmem_addr   = '0;
    bus.bmem_wdata  = '0;
    bus.i_dfp_resp  = 1'b0;
    bus.d_dfp_resp  = 1'b0;
    bus.i_dfp_rdata = i_rdata_q;
    bus.d_dfp_rdata = d_rdata_q;
    dbg_state       = state;
    case (state)
      RD_REQ: begin
        bus.bmem_read = 1'b1;
        bus.bmem_addr = addr_q;
      end
      WR_BURST: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = addr_q;
        bus.bmem_wdata = wdata_q[64*beat +: 64];
      end
      RESP: begin
        bus.i_dfp_resp = !owner;
        bus.d_dfp_resp = owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat       <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      mask_prev  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      mask_prev <= (state == RESP);
      if (grant) begin
        owner      <= grant_d;
        last_grant <= grant_d;
        addr_q     <= req_addr;
        if (grant_wr) wdata_q <= bus.d_dfp_wdata;
      end
      if (beat_done) beat <= (beat == LAST) ? '0 : beat + 1'b1;
      if ((state == RD_DATA) && bus.bmem_rvalid) begin
        line_q <= line_nxt;
        if (beat == LAST) begin
          if (owner) d_rdata_q <= line_nxt;
          else       i_rdata_q <= line_nxt;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    ((state == RD_DATA) && bus.bmem_rvalid) |-> (bus.bmem_raddr == addr_q))
    else $error("bmem_raddr does not match the outstanding burst address");

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: a burst-memory model and cache driver tasks.
// A response monitor pops expected responses, read addresses and write beats from queues.
module tb_bmem_arbiter;
  localparam int LINE_W = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_cmp = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bmem_arbiter_if #(.LINE_W(LINE_W)) bus ();
  bmem_arbiter #(.BEATS(4), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  logic [257:0] exp_q[$];        // {is_dcache, is_write, line}
  logic [31:0]  exp_raddr_q[$];
  logic [95:0]  exp_wbeat_q[$];  // {addr, beat data}
  logic [255:0] trk_i = '0, trk_d = '0;
  logic [63:0]  mem_line [4];
  int mem_latency = 1, mem_gap = 0, wr_stall_len = 0, wr_stall_beat = 1;
  int wr_acc = 0, stall_cnt = 0, beats_sent = 0;
  int last_hs_cyc = 0, last_i_resp_cyc = 0, last_d_resp_cyc = 0;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endfunction

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [257:0] e;
    if (!rst && (bus.i_dfp_resp || bus.d_dfp_resp)) begin
      if (bus.i_dfp_resp) last_i_resp_cyc = cyc;
      if (bus.d_dfp_resp) last_d_resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_resp", $sformatf("got i_resp=%0b d_resp=%0b, required none", bus.i_dfp_resp, bus.d_dfp_resp));
      end else begin
        e = exp_q.pop_front();
        check("resp_owner", 256'({bus.d_dfp_resp, bus.i_dfp_resp}), e[257] ? 256'd2 : 256'd1);
        if (e[257]) begin
          if (!e[256]) trk_d = e[255:0];
          check("d_rdata", bus.d_dfp_rdata, trk_d);
          check("i_rdata_unchanged", bus.i_dfp_rdata, trk_i);
        end else begin
          trk_i = e[255:0];
          check("i_rdata", bus.i_dfp_rdata, trk_i);
          check("d_rdata_unchanged", bus.d_dfp_rdata, trk_d);
        end
      end
    end
  end

  // ---------------- burst memory model ----------------
  initial begin
    logic [31:0] rd_addr;
    bus.bmem_ready  = 1'b1;
    bus.bmem_rvalid = 1'b0;
    bus.bmem_rdata  = '0;
    bus.bmem_raddr  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.bmem_ready  = 1'b1;
        bus.bmem_rvalid = 1'b0;
        continue;
      end
      if (bus.bmem_write) begin
        if (exp_wbeat_q.size() == 0) begin
          fail_now("unexpected_wbeat", $sformatf("got addr %h data %h, required no write", bus.bmem_addr, bus.bmem_wdata));
        end else begin
          check("wbeat", 256'({bus.bmem_addr, bus.bmem_wdata}), 256'(exp_wbeat_q[0]));
          if (bus.bmem_ready) begin
            exp_wbeat_q.delete(0);
            wr_acc++;
          end
        end
        @(posedge clk); #1;
        if (bus.bmem_ready && wr_stall_len > 0 && wr_acc == wr_stall_beat) begin
          bus.bmem_ready = 1'b0;
          stall_cnt      = wr_stall_len;
          wr_stall_len   = 0;
        end else if (!bus.bmem_ready) begin
          stall_cnt--;
          if (stall_cnt <= 0) bus.bmem_ready = 1'b1;
        end
      end else if (bus.bmem_read && bus.bmem_ready) begin
        rd_addr     = bus.bmem_addr;
        last_hs_cyc = cyc;
        if (exp_raddr_q.size() == 0)
          fail_now("unexpected_read", $sformatf("got read burst at %h, required none", rd_addr));
        else
          check("rd_addr", 256'(rd_addr), 256'(exp_raddr_q.pop_front()));
        @(posedge clk); #1;
        for (int w = 0; w < mem_latency; w++) if (!rst) begin @(posedge clk); #1; end
        for (int b = 0; b < 4; b++) begin
          if (rst) break;
          bus.bmem_rvalid = 1'b1;
          bus.bmem_rdata  = mem_line[b];
          bus.bmem_raddr  = rd_addr;
          @(posedge clk); #1;
          bus.bmem_rvalid = 1'b0;
          bus.bmem_rdata  = '0;
          beats_sent++;
          if (b < 3) for (int g = 0; g < mem_gap; g++) if (!rst) begin @(posedge clk); #1; end
        end
        bus.bmem_rvalid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_resp(input logic is_d);
    bit seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (is_d ? bus.d_dfp_resp : bus.i_dfp_resp) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("resp_timeout", $sformatf("got no resp for %s within 300 cycles, required one", is_d ? "dcache" : "icache"));
    // the cache keeps its request up for one more cycle after resp
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic icache_read(input logic [31:0] addr);
    bus.i_dfp_addr = addr;
    bus.i_dfp_read = 1'b1;
    wait_resp(1'b0);
    bus.i_dfp_read = 1'b0;
  endtask

  task automatic dcache_req(input logic [31:0] addr, input logic wr, input logic [255:0] line);
    bus.d_dfp_addr  = addr;
    bus.d_dfp_wdata = line;
    bus.d_dfp_read  = !wr;
    bus.d_dfp_write = wr;
    wait_resp(1'b1);
    bus.d_dfp_read  = 1'b0;
    bus.d_dfp_write = 1'b0;
  endtask

  task automatic exp_read(input logic is_d, input logic [31:0] addr, input logic [255:0] line);
    exp_q.push_back({is_d, 1'b0, line});
    exp_raddr_q.push_back(addr);
  endtask

  task automatic exp_write(input logic [31:0] addr, input logic [255:0] line);
    exp_q.push_back({1'b1, 1'b1, line});
    for (int b = 0; b < 4; b++) exp_wbeat_q.push_back({addr, line[64*b +: 64]});
  endtask

  task automatic set_mem(input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2, input logic [63:0] b3);
    mem_line[0] = b0; mem_line[1] = b1; mem_line[2] = b2; mem_line[3] = b3;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    trk_i = '0;
    trk_d = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 256'({bus.i_dfp_resp, bus.d_dfp_resp, bus.bmem_read, bus.bmem_write, bus.bmem_addr, bus.bmem_wdata}), '0);
    check({tag, "_i_rdata"}, bus.i_dfp_rdata, '0);
    check({tag, "_d_rdata"}, bus.d_dfp_rdata, '0);
    check({tag, "_state"}, 256'(dbg_state), '0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got no end of test by 500000 time units, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    bit ok;
    logic [255:0] wl;
    rst = 1'b1;
    bus.i_dfp_addr = '0; bus.i_dfp_read = 1'b0;
    bus.d_dfp_addr = '0; bus.d_dfp_read = 1'b0; bus.d_dfp_write = 1'b0; bus.d_dfp_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // icache read, aligned address, four distinct beats lowest first
    set_mem(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    exp_read(1'b0, 32'hAAAA_A000, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    t0 = cyc;
    icache_read(32'hAAAA_A004);
    check("t1_read_latency", 256'(last_i_resp_cyc - t0), 256'(7));

    // simultaneous reads straight after reset: icache first, dcache right after RESP+1
    do_reset();
    set_mem(64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D);
    exp_read(1'b0, 32'h0000_1040, {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                                   64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A});
    exp_read(1'b1, 32'h0000_2060, {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                                   64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A});
    fork
      icache_read(32'h0000_105C);
      dcache_req(32'h0000_207F, 1'b0, '0);
    join
    check("t2_d_handshake_after_i_resp", 256'(last_hs_cyc - last_i_resp_cyc), 256'(2));

    // dcache write with ready low for 3 cycles on the second beat
    wl = {64'hB0B0_0000_0000_0004, 64'hB0B0_0000_0000_0003, 64'hB0B0_0000_0000_0002, 64'hB0B0_0000_0000_0001};
    exp_write(32'h0000_1000, wl);
    wr_acc = 0;
    wr_stall_beat = 1;
    wr_stall_len = 3;
    t0 = cyc;
    dcache_req(32'h0000_1000, 1'b1, wl);
    check("t3_write_latency", 256'(last_d_resp_cyc - t0), 256'(8));

    // dcache read with 2-cycle gaps between beats
    set_mem(64'h5555_5555_0000_0000, 64'h6666_6666_0000_0001, 64'h7777_7777_0000_0002, 64'h8888_8888_0000_0003);
    mem_gap = 2;
    exp_read(1'b1, 32'h0000_3000, {64'h8888_8888_0000_0003, 64'h7777_7777_0000_0002,
                                   64'h6666_6666_0000_0001, 64'h5555_5555_0000_0000});
    t0 = cyc;
    dcache_req(32'h0000_3010, 1'b0, '0);
    check("t4_gap_read_latency", 256'(last_d_resp_cyc - t0), 256'(13));

    // reset after two beats of an icache read, then a fresh icache read
    set_mem(64'h9999_9999_9999_9999, 64'h9898_9898_9898_9898, 64'h9797_9797_9797_9797, 64'h9696_9696_9696_9696);
    beats_sent = 0;
    exp_raddr_q.push_back(32'h0000_4000);
    bus.i_dfp_addr = 32'h0000_4000;
    bus.i_dfp_read = 1'b1;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #2;
      if (beats_sent >= 2) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("t5_beat_timeout", "got fewer than 2 read beats in 100 cycles, required 2");
    rst = 1'b1;
    #1;
    check_outputs_zero("t5_abort");
    bus.i_dfp_read = 1'b0;
    trk_i = '0;
    trk_d = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_gap = 0;
    set_mem(64'hF00D_0000_0000_0000, 64'hF00D_0000_0000_0001, 64'hF00D_0000_0000_0002, 64'hF00D_0000_0000_0003);
    exp_read(1'b0, 32'h0000_4020, {64'hF00D_0000_0000_0003, 64'hF00D_0000_0000_0002,
                                   64'hF00D_0000_0000_0001, 64'hF00D_0000_0000_0000});
    icache_read(32'h0000_4024);

    // icache keeps requesting while a dcache write is pending: order I, D, I
    set_mem(64'hC0DE_0000_0000_0010, 64'hC0DE_0000_0000_0020, 64'hC0DE_0000_0000_0030, 64'hC0DE_0000_0000_0040);
    wl = {64'hE0E0_0000_0000_0044, 64'hE0E0_0000_0000_0033, 64'hE0E0_0000_0000_0022, 64'hE0E0_0000_0000_0011};
    exp_read(1'b0, 32'h0000_5000, {64'hC0DE_0000_0000_0040, 64'hC0DE_0000_0000_0030,
                                   64'hC0DE_0000_0000_0020, 64'hC0DE_0000_0000_0010});
    exp_write(32'h0000_6000, wl);
    exp_read(1'b0, 32'h0000_5020, {64'hC0DE_0000_0000_0040, 64'hC0DE_0000_0000_0030,
                                   64'hC0DE_0000_0000_0020, 64'hC0DE_0000_0000_0010});
    fork
      begin
        icache_read(32'h0000_5000);
        icache_read(32'h0000_5020);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        dcache_req(32'h0000_6000, 1'b1, wl);
      end
    join

    repeat (5) @(posedge clk);
    #1;
    check("drain_resp_q", 256'(exp_q.size()), '0);
    check("drain_raddr_q", 256'(exp_raddr_q.size()), '0);
    check("drain_wbeat_q", 256'(exp_wbeat_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
